div_seq: RTL and testbench

//  Multi-cycle sequencer and datapath for DIV/DIVU.
//  - Performs restoring radix-2 division, one quotient bit per cycle.
//  - Sits beside the execute stage:
//    - ex drives start_i/operands and holds stallreq_from_ex high until ready_o.
//    - ex then writes {remainder, quotient} to HI/LO via hi_o/lo_o/whilo_o.
//  - annul_i lets the pipeline cancel an in-flight divide (flush/exception).

---
 rtl/div_seq.sv | 119 +++++++++++
 tb/tb_div_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU beside the execute stage.
// Produces {remainder, quotient}; one quotient bit per cycle, cancellable by annul_i.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] work;
    logic [WIDTH-1:0] divisor;
    logic             sign1;
    logic             sign2;

    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] op1_mag;
    logic [WIDTH-1:0] op2_mag;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg = signed_div_i & opdata2_i[WIDTH-1];
        op1_mag = op1_neg ? ('0 - opdata1_i) : opdata1_i;
        op2_mag = op2_neg ? ('0 - opdata2_i) : opdata2_i;
        // Partial remainder minus divisor; msb set means it does not fit.
        diff    = work[2*WIDTH:WIDTH] - {1'b0, divisor};
        quo     = (sign1 ^ sign2) ? ('0 - work[WIDTH-1:0]) : work[WIDTH-1:0];
        rem     = sign1 ? ('0 - work[2*WIDTH:WIDTH+1]) : work[2*WIDTH:WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state   <= ON;
                            cnt     <= '0;
                            work    <= {{WIDTH{1'b0}}, op1_mag, 1'b0};
                            divisor <= op2_mag;
                            sign1   <= op1_neg;
                            sign2   <= op2_neg;
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        state    <= END;
                        work     <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b0;
                    end else if (cnt != CW'(WIDTH)) begin
                        if (diff[WIDTH])
                            work <= {work[2*WIDTH-1:0], 1'b0};
                        else
                            work <= {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
                        cnt <= cnt + CW'(1);
                    end else begin
                        result_o <= {rem, quo};
                        ready_o  <= 1'b1;
                        state    <= END;
                        cnt      <= '0;
                    end
                end
                END: begin
                    if (!start_i || annul_i) begin
                        state    <= IDLE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random divides
// compared against a plain-arithmetic reference model.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_errors = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Truncating division; remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a,
                                            input logic [31:0] b);
        longint q;
        longint r;
        longint sa;
        longint sb;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input string tag, input bit s,
                           input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [63:0] exp;
        exp = ref_div(s, a, b);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            // Operands must be ignored once the request is accepted.
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
        end while (!ready_o && n < 60);
        check({tag, "_lat"}, 64'(n - 1), (b == 32'd0) ? 64'd1 : 64'd33);
        check({tag, "_res"}, result_o, exp);
        @(negedge clk);
        check({tag, "_hold"}, {63'd0, ready_o}, 64'd1);
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "_drop"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    initial begin
        int rises;
        bit s;
        logic [31:0] a;
        logic [31:0] b;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div("divu_7_2", 1'b0, 32'd7, 32'd2);
        check("divu_7_2_const", ref_div(1'b0, 32'd7, 32'd2),
              64'h00000001_00000003);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("divu_big", 1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_div("divu_zero", 1'b0, 32'd1234, 32'd0);
        run_div("div_zero", 1'b1, 32'h8000_0000, 32'd0);

        // Start and annul together in IDLE: annul wins.
        opdata1_i = 32'd9;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_annul", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        @(negedge clk);

        // Annul mid-divide: the cancelled op must never complete.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rises++;
        end
        check("annul_no_ready", 64'(rises), 64'd0);
        run_div("after_annul", 1'b1, 32'hFFFF_FC18, 32'd7);

        // Reset in the middle of a divide.
        signed_div_i = 1'b0;
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_on", {result_o[62:0], ready_o}, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rises++;
        end
        check("rst_no_ready", 64'(rises), 64'd0);

        // Reset while a result is being held.
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        repeat (2) @(negedge clk);
        check("end_ready", {63'd0, ready_o}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_end", {result_o[62:0], ready_o}, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            int r;
            s = 1'($urandom);
            a = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0)
                b = 32'd0;
            else if (r < 4)
                b = $urandom_range(1, 15);
            else
                b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if (s && $urandom_range(0, 1) == 1 && r < 4) b = '0 - b;
            run_div($sformatf("rnd%0d", i), s, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
